// File: rtl/bin2bcd_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_scan_if
// Brief   : Value handshake and scanned digit bus for bin2bcd_scan.
// Revision: 1.0
// ============================================================================
interface bin2bcd_scan_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic              w_in_valid;
  logic [WIDTH-1:0]  w_in_data;
  logic              r_in_ready;
  logic              r_busy;
  logic [DIGITS-1:0] r_sel;
  logic [3:0]        w_digit;

  modport master (
    output w_in_valid, w_in_data,
    input  r_in_ready, r_busy, r_sel, w_digit
  );

  modport slave (
    input  w_in_valid, w_in_data,
    output r_in_ready, r_busy, r_sel, w_digit
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_scan.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_scan
// Brief   : Serial double-dabble binary-to-BCD converter with one-hot digit scan.
// Revision: 1.0
// ============================================================================
module bin2bcd_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4,
  parameter int BLANK    = 1
) (
  input  wire logic      w_clk,
  input  wire logic      w_rst,
  bin2bcd_scan_if.slave  bus
);

  // Decimal digits needed for 2^WIDTH-1: ceil(WIDTH*log10(2)).
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam int BCD_W      = 4 * DIGITS;
  localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("bin2bcd_scan: WIDTH must be at least 1");
    end
    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
      $error("bin2bcd_scan: DIGITS too small to hold a WIDTH-bit value");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("bin2bcd_scan: SCAN_DIV must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    shift_q;
  logic [WIDTH-1:0]    shift_d;
  logic [BCD_W-1:0]    work_q;
  logic [BCD_W-1:0]    work_d;
  logic [BCD_W-1:0]    work_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic [BCD_W-1:0]    disp_q;
  logic                ready_q;
  logic                busy_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [DIGITS-1:0]   sel_q;
  logic [DIGITS-1:0]   sel_d;
  logic [DIGITS:0]     upper_zero;
  logic [3:0]          digit_mux;

  // One double-dabble iteration: add-3 correction, then shift the pair left.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_d  = {work_adj[BCD_W-2:0], shift_q[WIDTH-1]};
    shift_d = shift_q << 1;
  end

  always_comb begin
    sel_d = (sel_q << 1) | (sel_q >> (DIGITS - 1));
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      scan_q  <= '0;
      sel_q   <= DIGITS'(1);
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        sel_q  <= sel_d;
      end else begin
        scan_q <= scan_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.w_in_valid && ready_q) begin
            shift_q <= bus.w_in_data;
            work_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          shift_q <= shift_d;
          work_q  <= work_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            disp_q  <= work_d;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // upper_zero[i]: display digits i..DIGITS-1 are all zero.
  always_comb begin
    upper_zero         = '0;
    upper_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero[i] = (disp_q[4*i +: 4] == 4'd0) && upper_zero[i+1];
    end
  end

  always_comb begin
    digit_mux = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) begin
        if ((BLANK != 0) && (i > 0) && upper_zero[i]) begin
          digit_mux = 4'hF;
        end else begin
          digit_mux = disp_q[4*i +: 4];
        end
      end
    end
  end

  assign bus.r_in_ready = ready_q;
  assign bus.r_busy     = busy_q;
  assign bus.r_sel      = sel_q;
  assign bus.w_digit    = digit_mux;

endmodule
`default_nettype wire
